// File: rtl/console_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_writer_pkg - shared types and constants for the console writer   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package console_writer_pkg;

   localparam int DEF_COLS = 80;
   localparam int DEF_ROWS = 30;

   localparam int ROW_W  = 6;
   localparam int COL_W  = 7;
   localparam int ADDR_W = ROW_W + COL_W;

   typedef logic [ROW_W-1:0] row_t;
   typedef logic [COL_W-1:0] col_t;

   localparam logic [7:0] CC_BS    = 8'h08;
   localparam logic [7:0] CC_TAB   = 8'h09;
   localparam logic [7:0] CC_LF    = 8'h0A;
   localparam logic [7:0] CC_FF    = 8'h0C;
   localparam logic [7:0] CC_CR    = 8'h0D;
   localparam logic [7:0] CC_BLANK = 8'h20;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_CLEAR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/console_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_writer_if - byte input stream plus character/attribute RAM port  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface console_writer_if;
   import console_writer_pkg::*;

   logic [7:0]        in_char;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] ram_address;
   logic [7:0]        ram_char_data;
   logic [7:0]        ram_attr_data;
   logic              ram_char_we;
   logic              ram_attr_we;

   // master: host side feeding bytes and observing RAM writes
   modport master (
      output in_char, in_valid,
      input  in_ready, ram_address, ram_char_data, ram_attr_data,
             ram_char_we, ram_attr_we
   );

   // slave: the writer itself
   modport slave (
      input  in_char, in_valid,
      output in_ready, ram_address, ram_char_data, ram_attr_data,
             ram_char_we, ram_attr_we
   );

endinterface
`default_nettype wire

// File: rtl/console_cursor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_cursor - combinational next-cursor for printable/CR/LF/BS/TAB    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module console_cursor
   import console_writer_pkg::*;
#(
   parameter int COLS = DEF_COLS,
   parameter int ROWS = DEF_ROWS
) (
   input  row_t       i_row,
   input  col_t       i_col,
   input  logic [7:0] i_code,
   output row_t       o_row,
   output col_t       o_col
);

   localparam row_t           c_last_row = row_t'(ROWS - 1);
   localparam col_t           c_last_col = col_t'(COLS - 1);
   localparam logic [COL_W:0] c_cols_x   = COLS[COL_W:0];

   row_t           w_row_inc;
   logic [COL_W:0] w_tab_col;

   // no scrolling: moving past the last row lands back on row 0
   assign w_row_inc = (i_row == c_last_row) ? '0 : i_row + 1'b1;
   assign w_tab_col = {1'b0, i_col | col_t'(7)} + 1'b1;

   always_comb begin
      o_row = i_row;
      o_col = i_col;
      case (i_code)
         CC_CR: o_col = '0;
         CC_LF: begin
            o_col = '0;
            o_row = w_row_inc;
         end
         CC_BS: begin
            if (i_col != '0) o_col = i_col - 1'b1;
         end
         CC_TAB: begin
            if (w_tab_col >= c_cols_x) begin
               o_col = '0;
               o_row = w_row_inc;
            end else begin
               o_col = w_tab_col[COL_W-1:0];
            end
         end
         default: begin
            if (i_col == c_last_col) begin
               o_col = '0;
               o_row = w_row_inc;
            end else begin
               o_col = i_col + 1'b1;
            end
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/console_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_writer - byte stream to char/attr RAM writer; clear-screen engine|
// | built only with CONSOLE_WRITER_CLS_EN.  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module console_writer
   import console_writer_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter logic [7:0] RESET_ATTR = 8'h0F
) (
   input  logic                   clk,
   input  logic                   reset,
   console_writer_if.slave        bus,
   input  logic [7:0]             attr_in,
   input  logic                   attr_load,
   output row_t                   cursor_row,
   output col_t                   cursor_col,
   output logic                   busy
);

   logic [7:0]        cur_attr_q, cur_attr_d;
   row_t              row_q, row_d;
   col_t              col_q, col_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wchar_q, wchar_d;
   logic [7:0]        wattr_q, wattr_d;

   row_t       w_next_row;
   col_t       w_next_col;
   logic [7:0] w_attr_eff;
   logic       w_accept;
   logic       w_is_ctrl;

   console_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .i_row  (row_q),
      .i_col  (col_q),
      .i_code (bus.in_char),
      .o_row  (w_next_row),
      .o_col  (w_next_col)
   );

   // a same-cycle attr_load applies to the byte or cell being written now
   assign w_attr_eff = attr_load ? attr_in : cur_attr_q;
   assign w_accept   = bus.in_valid & bus.in_ready;
   assign w_is_ctrl  = (bus.in_char == CC_BS) | (bus.in_char == CC_TAB) |
                       (bus.in_char == CC_LF) | (bus.in_char == CC_CR);

`ifdef CONSOLE_WRITER_CLS_EN
   localparam row_t c_last_row = row_t'(ROWS - 1);
   localparam col_t c_last_col = col_t'(COLS - 1);

   state_t state_q, state_d;
   row_t   clr_row_q, clr_row_d;
   col_t   clr_col_q, clr_col_d;
   logic   clr_done_q, clr_done_d;

   assign bus.in_ready = ~reset & (state_q == ST_IDLE);
   assign busy         = (state_q == ST_CLEAR);
`else
   assign bus.in_ready = ~reset;
   assign busy         = 1'b0;
`endif

   always_comb begin
      cur_attr_d = w_attr_eff;
      row_d      = row_q;
      col_d      = col_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wchar_d    = wchar_q;
      wattr_d    = wattr_q;
`ifdef CONSOLE_WRITER_CLS_EN
      state_d    = state_q;
      clr_row_d  = clr_row_q;
      clr_col_d  = clr_col_q;
      clr_done_d = clr_done_q;
      if (state_q == ST_CLEAR) begin
         if (clr_done_q) begin
            state_d    = ST_IDLE;
            row_d      = '0;
            col_d      = '0;
            clr_done_d = 1'b0;
         end else begin
            we_d       = 1'b1;
            addr_d     = {clr_row_q, clr_col_q};
            wchar_d    = CC_BLANK;
            wattr_d    = w_attr_eff;
            clr_done_d = (clr_row_q == c_last_row) && (clr_col_q == c_last_col);
            if (clr_col_q == c_last_col) begin
               clr_col_d = '0;
               clr_row_d = clr_row_q + 1'b1;
            end else begin
               clr_col_d = clr_col_q + 1'b1;
            end
         end
      end else if (w_accept && (bus.in_char == CC_FF)) begin
         // cell (0,0) is written on the accepting edge so the sweep fills
         // exactly ROWS*COLS cycles; the counter therefore resumes at (0,1)
         state_d    = ST_CLEAR;
         we_d       = 1'b1;
         addr_d     = '0;
         wchar_d    = CC_BLANK;
         wattr_d    = w_attr_eff;
         clr_row_d  = '0;
         clr_col_d  = col_t'(1);
         clr_done_d = 1'b0;
      end else
`endif
      if (w_accept) begin
         row_d = w_next_row;
         col_d = w_next_col;
         if (!w_is_ctrl) begin
            we_d    = 1'b1;
            addr_d  = {row_q, col_q};
            wchar_d = bus.in_char;
            wattr_d = w_attr_eff;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_attr_q <= RESET_ATTR;
         row_q      <= '0;
         col_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wchar_q    <= '0;
         wattr_q    <= '0;
      end else begin
         cur_attr_q <= cur_attr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wchar_q    <= wchar_d;
         wattr_q    <= wattr_d;
      end
   end

`ifdef CONSOLE_WRITER_CLS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         clr_row_q  <= '0;
         clr_col_q  <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_row_q  <= clr_row_d;
         clr_col_q  <= clr_col_d;
         clr_done_q <= clr_done_d;
      end
   end
`endif

   assign bus.ram_address   = addr_q;
   assign bus.ram_char_data = wchar_q;
   assign bus.ram_attr_data = wattr_q;
   assign bus.ram_char_we   = we_q;
   assign bus.ram_attr_we   = we_q;
   assign cursor_row        = row_q;
   assign cursor_col        = col_q;

endmodule
`default_nettype wire

// File: tb/tb_console_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_console_writer - directed vector bench for console_writer             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_console_writer;
   import console_writer_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] attr_in;
   logic       attr_load;
   row_t       cursor_row;
   col_t       cursor_col;
   logic       busy;

   int n_pass   = 0;
   int n_total  = 0;
   int wr_cnt   = 0;
   int we_split = 0;

   console_writer_if bus ();

   console_writer #(
      .COLS       (80),
      .ROWS       (30),
      .RESET_ATTR (8'h0F)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .attr_in    (attr_in),
      .attr_load  (attr_load),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.ram_char_we) wr_cnt++;
      if (bus.ram_char_we !== bus.ram_attr_we) we_split++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [7:0]  code;
      logic        ld;
      logic [7:0]  attr;
      logic        we;
      logic [12:0] addr;
      logic [7:0]  ch;
      logic [7:0]  at;
      logic [5:0]  row;
      logic [6:0]  col;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // inputs change #1 after a rising edge; outputs are sampled there too
   task automatic send(input logic [7:0] c);
      bus.in_char  = c;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rst_pulse();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic goto_col79();
      repeat (9) send(CC_TAB);
      repeat (7) send(8'h70);
   endtask

   int c0;
   int k, nw, nbusy, nbad;
   logic [12:0] first_a, last_a;

   initial begin
      vecs[0]  = '{8'h41, 1'b0, 8'h00, 1'b1, 13'h000, 8'h41, 8'h0F, 6'd0, 7'd1};
      vecs[1]  = '{8'h42, 1'b0, 8'h00, 1'b1, 13'h001, 8'h42, 8'h0F, 6'd0, 7'd2};
      vecs[2]  = '{8'h43, 1'b0, 8'h00, 1'b1, 13'h002, 8'h43, 8'h0F, 6'd0, 7'd3};
      vecs[3]  = '{8'h44, 1'b0, 8'h00, 1'b1, 13'h003, 8'h44, 8'h0F, 6'd0, 7'd4};
      vecs[4]  = '{8'h45, 1'b0, 8'h00, 1'b1, 13'h004, 8'h45, 8'h0F, 6'd0, 7'd5};
      vecs[5]  = '{8'h09, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd0, 7'd8};
      vecs[6]  = '{8'h08, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd0, 7'd7};
      vecs[7]  = '{8'h0D, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd0, 7'd0};
      vecs[8]  = '{8'h08, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd0, 7'd0};
      vecs[9]  = '{8'h0A, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd1, 7'd0};
      vecs[10] = '{8'h58, 1'b1, 8'h1E, 1'b1, 13'h080, 8'h58, 8'h1E, 6'd1, 7'd1};
      vecs[11] = '{8'h59, 1'b0, 8'h00, 1'b1, 13'h081, 8'h59, 8'h1E, 6'd1, 7'd2};
      vecs[12] = '{8'h09, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd1, 7'd8};
      vecs[13] = '{8'h09, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd1, 7'd16};
      vecs[14] = '{8'h08, 1'b0, 8'h00, 1'b0, 13'h000, 8'h00, 8'h00, 6'd1, 7'd15};
      vecs[15] = '{8'h0D, 1'b1, 8'h2A, 1'b0, 13'h000, 8'h00, 8'h00, 6'd1, 7'd0};
      vecs[16] = '{8'h5A, 1'b0, 8'h00, 1'b1, 13'h080, 8'h5A, 8'h2A, 6'd1, 7'd1};
      vecs[17] = '{8'h7E, 1'b0, 8'h00, 1'b1, 13'h081, 8'h7E, 8'h2A, 6'd1, 7'd2};

      reset        = 1'b1;
      bus.in_char  = 8'h00;
      bus.in_valid = 1'b0;
      attr_in      = 8'h00;
      attr_load    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_we",       bus.ram_char_we, 0);
      check("rst_addr",     bus.ram_address, 0);
      check("rst_char",     bus.ram_char_data, 0);
      check("rst_attr",     bus.ram_attr_data, 0);
      check("rst_row",      cursor_row, 0);
      check("rst_col",      cursor_col, 0);
      check("rst_busy",     busy, 0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);

      for (int i = 0; i < 18; i++) begin
         attr_load = vecs[i].ld;
         attr_in   = vecs[i].attr;
         send(vecs[i].code);
         attr_load = 1'b0;
         check($sformatf("v%0d_we", i), bus.ram_char_we, vecs[i].we);
         if (vecs[i].we) begin
            check($sformatf("v%0d_addr", i), bus.ram_address, vecs[i].addr);
            check($sformatf("v%0d_char", i), bus.ram_char_data, vecs[i].ch);
            check($sformatf("v%0d_attr", i), bus.ram_attr_data, vecs[i].at);
         end
         check($sformatf("v%0d_row", i), cursor_row, vecs[i].row);
         check($sformatf("v%0d_col", i), cursor_col, vecs[i].col);
      end

      // row/column wrap via LF and TAB, with no strobes
      rst_pulse();
      idle(2);
      c0 = wr_cnt;
      repeat (29) send(CC_LF);
      check("lf29_row", cursor_row, 29);
      repeat (9) send(CC_TAB);
      check("tab9_col", cursor_col, 72);
      send(CC_TAB);
      check("tabwrap_row", cursor_row, 0);
      check("tabwrap_col", cursor_col, 0);
      repeat (29) send(CC_LF);
      send(CC_LF);
      check("lfwrap_row", cursor_row, 0);
      idle(2);
      check("ctrl_no_writes", wr_cnt - c0, 0);

      repeat (29) send(CC_LF);
      goto_col79();
      check("pre_last_row", cursor_row, 29);
      check("pre_last_col", cursor_col, 79);
      send(8'h41);
      check("last_we",   bus.ram_char_we, 1);
      check("last_addr", bus.ram_address, 13'h0ECF);
      check("last_char", bus.ram_char_data, 8'h41);
      check("last_row",  cursor_row, 0);
      check("last_col",  cursor_col, 0);
      idle(1);
      check("last_we_one_cycle", bus.ram_char_we, 0);

      rst_pulse();
      goto_col79();
      send(8'h41);
      check("eol_we",   bus.ram_char_we, 1);
      check("eol_addr", bus.ram_address, 13'h004F);
      check("eol_row",  cursor_row, 1);
      check("eol_col",  cursor_col, 0);
      send(CC_BS);
      check("bs_col0_row", cursor_row, 1);
      check("bs_col0_col", cursor_col, 0);

`ifdef CONSOLE_WRITER_CLS_EN
      rst_pulse();
      attr_in   = 8'h5C;
      attr_load = 1'b1;
      send(8'h41);
      attr_load = 1'b0;
      bus.in_char  = CC_FF;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_char = 8'h51;
      k = 1; nw = 0; nbusy = 0; nbad = 0; first_a = '1; last_a = '0;
      while (!bus.in_ready && k < 3000) begin
         if (bus.ram_char_we) begin
            if (nw == 0) first_a = bus.ram_address;
            last_a = bus.ram_address;
            nw++;
            if (bus.ram_address[6:0] >= 7'd80 || bus.ram_char_data != 8'h20 ||
                bus.ram_attr_data != 8'h5C) nbad++;
         end
         if (busy) nbusy++;
         @(posedge clk); #1;
         k++;
      end
      check("clr_ready_cycle", k, 2401);
      check("clr_writes",      nw, 2400);
      check("clr_first_addr",  first_a, 13'h0000);
      check("clr_last_addr",   last_a, 13'h0ECF);
      check("clr_bad_cells",   nbad, 0);
      check("clr_busy_cycles", nbusy, 2400);
      check("clr_done_busy",   busy, 0);
      check("clr_done_we",     bus.ram_char_we, 0);
      check("clr_done_row",    cursor_row, 0);
      check("clr_done_col",    cursor_col, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("held_byte_we",   bus.ram_char_we, 1);
      check("held_byte_addr", bus.ram_address, 0);
      check("held_byte_char", bus.ram_char_data, 8'h51);
      check("held_byte_col",  cursor_col, 1);

      send(CC_FF);
      idle(99);
      check("abort_pre_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_we",       bus.ram_char_we, 0);
      check("abort_busy",     busy, 0);
      check("abort_in_ready", bus.in_ready, 0);
      check("abort_row",      cursor_row, 0);
      check("abort_col",      cursor_col, 0);
      reset = 1'b0;
      c0 = wr_cnt;
      idle(20);
      check("abort_no_writes", wr_cnt - c0, 0);
      check("abort_ready",     bus.in_ready, 1);
`else
      rst_pulse();
      send(CC_FF);
      check("ff_glyph_we",    bus.ram_char_we, 1);
      check("ff_glyph_addr",  bus.ram_address, 0);
      check("ff_glyph_char",  bus.ram_char_data, 8'h0C);
      check("ff_glyph_attr",  bus.ram_attr_data, 8'h0F);
      check("ff_glyph_col",   cursor_col, 1);
      check("ff_glyph_busy",  busy, 0);
      check("ff_glyph_ready", bus.in_ready, 1);
`endif

      check("we_strobes_equal", we_split, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
